// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants, state encoding and row slicing for the matrix scanner
// Purpose: geometry constants of the 8x16 glyph bitmap, the scanner FSM state
//          enum and a helper that extracts one row's 16 column bits.
// Ports:   none (package).
package matrix_pkg;

   localparam int ROWS    = 8;
   localparam int COLS    = 16;
   localparam int FRAME_W = 128;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      LATCH,
      DISPLAY
   } state_e;

   // Row r occupies frame[127-16r -: 16]; column 0 lands in bit 15 of the result.
   function automatic logic [COLS-1:0] row_bits(input logic [FRAME_W-1:0] frame,
                                                input logic [2:0]         r);
      logic [FRAME_W-1:0] shifted;
      shifted = frame << (COLS * int'(r));
      return shifted[FRAME_W-1 -: COLS];
   endfunction

endpackage

// File: rtl/row_shifter.sv
// rtl/row_shifter.sv - 16-bit PISO with sclk divider for one matrix row
// Purpose: on start_i, loads data_i and serialises it MSB (column 0) first.
//          Each bit holds sdata_o with sclk_o low for DIV cycles, then high
//          for DIV cycles. done_o flags the last high-phase cycle of bit 15.
// Ports:   clk_i, rst_ni (async, active low), start_i, data_i[15:0],
//          done_o, sdata_o, sclk_o (both registered).
module row_shifter
   import matrix_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [COLS-1:0] data_i,
   output logic            done_o,
   output logic            sdata_o,
   output logic            sclk_o
);

   localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   logic [COLS-1:0] shreg_q, shreg_d;
   logic [DW-1:0]   div_q, div_d;
   logic [3:0]      bit_q, bit_d;
   logic            active_q, active_d;
   logic            sdata_q, sdata_d;
   logic            sclk_q, sclk_d;
   logic            phase_end;

   assign phase_end = (div_q == DIV_LAST);
   assign done_o    = active_q && sclk_q && phase_end && (bit_q == 4'd15);
   assign sdata_o   = sdata_q;
   assign sclk_o    = sclk_q;

   always_comb begin
      shreg_d  = shreg_q;
      div_d    = div_q;
      bit_d    = bit_q;
      active_d = active_q;
      sdata_d  = sdata_q;
      sclk_d   = sclk_q;
      if (start_i) begin
         // Column 0 goes out immediately; the rest waits in the shift register.
         shreg_d  = data_i << 1;
         sdata_d  = data_i[COLS-1];
         sclk_d   = 1'b0;
         div_d    = '0;
         bit_d    = 4'd0;
         active_d = 1'b1;
      end else if (active_q) begin
         if (phase_end) begin
            div_d = '0;
            if (!sclk_q) begin
               sclk_d = 1'b1;
            end else begin
               sclk_d = 1'b0;
               // Bit counter wraps 15->0 exactly when the row is finished.
               bit_d  = bit_q + 4'd1;
               if (bit_q == 4'd15) begin
                  active_d = 1'b0;
               end else begin
                  sdata_d = shreg_q[COLS-1];
                  shreg_d = shreg_q << 1;
               end
            end
         end else begin
            div_d = div_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shreg_q  <= '0;
         div_q    <= '0;
         bit_q    <= 4'd0;
         active_q <= 1'b0;
         sdata_q  <= 1'b0;
         sclk_q   <= 1'b0;
      end else begin
         shreg_q  <= shreg_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         active_q <= active_d;
         sdata_q  <= sdata_d;
         sclk_q   <= sclk_d;
      end
   end

endmodule

// File: rtl/matrix_scanner.sv
// rtl/matrix_scanner.sv - row-multiplexed LED matrix scanner for an 8x16 glyph bitmap
// Purpose: snapshots frame once per frame, shifts each row into an external
//          latching shift chain, latches it with blanking, then holds it for
//          DWELL cycles. All outputs are registered and change together with
//          the state they belong to.
// Ports:   clk, rst_n (async, active low), en, frame[127:0];
//          sdata, sclk, slatch, oe_n (active low), row_sel[7:0] (one-hot),
//          frame_done (pulse on last row-7 dwell cycle), busy.
module matrix_scanner
   import matrix_pkg::*;
#(
   parameter int DIV   = 4,
   parameter int DWELL = 1000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [FRAME_W-1:0] frame,
   output logic               sdata,
   output logic               sclk,
   output logic               slatch,
   output logic               oe_n,
   output logic [ROWS-1:0]    row_sel,
   output logic               frame_done,
   output logic               busy
);

   localparam int            WW         = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [WW-1:0] DWELL_LAST = WW'(DWELL - 1);

   state_e             state_q, state_d;
   logic [2:0]         row_q, row_d;
   logic [FRAME_W-1:0] snap_q, snap_d;
   logic [WW-1:0]      dwell_q, dwell_d;
   logic               slatch_q, slatch_d;
   logic               oe_n_q, oe_n_d;
   logic [ROWS-1:0]    row_sel_q, row_sel_d;
   logic               frame_done_q, frame_done_d;
   logic               busy_q, busy_d;
   logic               sh_start, sh_done;
   logic [COLS-1:0]    sh_data;

   row_shifter #(.DIV(DIV)) u_row_shifter (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .start_i (sh_start),
      .data_i  (sh_data),
      .done_o  (sh_done),
      .sdata_o (sdata),
      .sclk_o  (sclk)
   );

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      snap_d  = snap_q;
      case (state_q)
         IDLE:    if (en) state_d = LOAD;
         LOAD: begin
            snap_d  = frame;
            row_d   = 3'd0;
            state_d = SHIFT;
         end
         SHIFT:   if (sh_done) state_d = LATCH;
         LATCH:   state_d = DISPLAY;
         DISPLAY: begin
            if (dwell_q == DWELL_LAST) begin
               if (row_q != 3'd7) begin
                  row_d   = row_q + 3'd1;
                  state_d = SHIFT;
               end else begin
                  state_d = en ? LOAD : IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      dwell_d = (state_q == DISPLAY && state_d == DISPLAY) ? dwell_q + WW'(1) : '0;

      // Row 0 is fetched straight from frame while the snapshot is still being written.
      sh_start = (state_d == SHIFT) && (state_q != SHIFT);
      sh_data  = (state_q == LOAD) ? row_bits(frame, 3'd0) : row_bits(snap_q, row_d);

      // Outputs are decoded from the next state so they line up with it.
      slatch_d     = (state_d == LATCH);
      busy_d       = (state_d != IDLE);
      frame_done_d = (state_d == DISPLAY) && (dwell_d == DWELL_LAST) && (row_q == 3'd7);
      oe_n_d       = oe_n_q;
      row_sel_d    = row_sel_q;
      case (state_d)
         IDLE: begin
            oe_n_d    = 1'b1;
            row_sel_d = '0;
         end
         LATCH: begin
            oe_n_d    = 1'b1;
            row_sel_d = ROWS'(1) << row_q;
         end
         DISPLAY: oe_n_d = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         row_q        <= 3'd0;
         snap_q       <= '0;
         dwell_q      <= '0;
         slatch_q     <= 1'b0;
         oe_n_q       <= 1'b1;
         row_sel_q    <= '0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         snap_q       <= snap_d;
         dwell_q      <= dwell_d;
         slatch_q     <= slatch_d;
         oe_n_q       <= oe_n_d;
         row_sel_q    <= row_sel_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign slatch     = slatch_q;
   assign oe_n       = oe_n_q;
   assign row_sel    = row_sel_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_matrix_scanner.sv
// tb/tb_matrix_scanner.sv - directed bench for matrix_scanner
module tb_matrix_scanner;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en1, en3;
   logic [127:0] frame1, frame3;

   logic       sdata1, sclk1, slatch1, oe_n1, frame_done1, busy1;
   logic [7:0] row_sel1;
   logic       sdata3, sclk3, slatch3, oe_n3, frame_done3, busy3;
   logic [7:0] row_sel3;
   logic [13:0] outs1, outs3;

   localparam logic [13:0] RST_OUTS = {1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
   localparam logic [127:0] F_A = 128'h0000E000_00000000_00000000_00000000;
   localparam logic [127:0] F_B = 128'h00000000_00000000_00008001_00000000;
   localparam logic [127:0] F_3 = 128'hA5C30000_00000000_00000000_00000F0F;

   always #5 clk = ~clk;

   matrix_scanner #(.DIV(1), .DWELL(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en1), .frame(frame1),
      .sdata(sdata1), .sclk(sclk1), .slatch(slatch1), .oe_n(oe_n1),
      .row_sel(row_sel1), .frame_done(frame_done1), .busy(busy1)
   );

   matrix_scanner #(.DIV(3), .DWELL(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .en(en3), .frame(frame3),
      .sdata(sdata3), .sclk(sclk3), .slatch(slatch3), .oe_n(oe_n3),
      .row_sel(row_sel3), .frame_done(frame_done3), .busy(busy3)
   );

   assign outs1 = {sdata1, sclk1, slatch1, oe_n1, row_sel1, frame_done1, busy1};
   assign outs3 = {sdata3, sclk3, slatch3, oe_n3, row_sel3, frame_done3, busy3};

   int n_cmp = 0;
   int n_err = 0;

   int          t;
   logic        prev_sclk;
   logic [15:0] word;
   int          nrise;
   logic [15:0] lat_q[$];
   int          rise_q[$];
   int          lat_t[$];
   int          fd_t[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic observe1();
      if (sclk1 && !prev_sclk) begin
         word = {word[14:0], sdata1};
         nrise++;
      end
      prev_sclk = sclk1;
      if (slatch1) begin
         lat_q.push_back(word);
         rise_q.push_back(nrise);
         lat_t.push_back(t);
         word  = '0;
         nrise = 0;
      end
      if (frame_done1) fd_t.push_back(t);
   endtask

   task automatic step1();
      tick();
      t++;
      observe1();
   endtask

   task automatic run1_to(input int target);
      while (t < target) step1();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      int dev;
      int bad;
      int p_sclk, p_sdata, run, last_change, last_rise, nr, nlat, lt0, fd3;
      int bad_len, bad_setup, bad_hold, bad_rises;
      logic [15:0] word3, w0, w7;

      rst_n = 1'b0; en1 = 1'b0; en3 = 1'b0; frame1 = '0; frame3 = '0;
      repeat (3) tick();
      chk("reset_outs1", outs1, RST_OUTS);
      chk("reset_outs3", outs3, RST_OUTS);

      // Released with en low: nothing may move for 1000 cycles.
      rst_n = 1'b1;
      dev = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (outs1 !== RST_OUTS) dev++;
      end
      chk("idle_hold_1000", dev, 0);

      // Frame 1: row 1 = E000.
      frame1 = F_A; en1 = 1'b1;
      guard = 0;
      while (!busy1 && guard < 10) begin tick(); guard++; end
      chk("load_after_en", guard, 1);
      t = 1; prev_sclk = 1'b0; word = '0; nrise = 0;
      observe1();
      step1();
      chk("sclk_low_on_shift_entry", sclk1, 1'b0);
      step1();
      chk("first_sclk_rise", sclk1, 1'b1);
      run1_to(71);
      chk("latch_row1_blanked", {slatch1, oe_n1, row_sel1}, {1'b1, 1'b1, 8'h02});
      step1();
      chk("display_row1", {slatch1, oe_n1, row_sel1}, {1'b0, 1'b0, 8'h02});
      run1_to(297);
      chk("frame_done_297", frame_done1, 1'b1);
      chk("latches_frame1", lat_q.size(), 8);
      chk("latch0_time", lat_t[0], 34);
      chk("latch1_time", lat_t[1], 71);
      chk("row0_bits", lat_q[0], 16'h0000);
      chk("row1_bits", lat_q[1], 16'hE000);
      chk("row1_rises", rise_q[1], 16);
      step1();
      chk("reload_298", {busy1, frame_done1}, {1'b1, 1'b0});

      // Change frame during row 3 of frame 2: snapshot must protect it.
      run1_to(445);
      frame1 = F_B;
      run1_to(594);
      chk("latches_frame2", lat_q.size(), 16);
      chk("f2_row1_old", lat_q[9], 16'hE000);
      chk("f2_row5_old", lat_q[13], 16'h0000);

      // Drop en during row 2 of frame 3.
      run1_to(700);
      en1 = 1'b0;
      run1_to(891);
      chk("frame_done_891", frame_done1, 1'b1);
      step1();
      chk("idle_after_drop", {busy1, oe_n1, row_sel1}, {1'b0, 1'b1, 8'h00});
      chk("latches_frame3", lat_q.size(), 24);
      chk("f3_row1_new", lat_q[17], 16'h0000);
      chk("f3_row5_new", lat_q[21], 16'h8001);
      bad = 0;
      foreach (rise_q[i]) if (rise_q[i] != 16) bad++;
      chk("rises_per_latch_div1", bad, 0);
      chk("frame_done_count", fd_t.size(), 3);
      chk("frame_done_f2", fd_t[1], 594);
      run1_to(900);
      chk("stays_idle", busy1, 1'b0);

      // Reset during SHIFT of row 5.
      en1 = 1'b1;
      guard = 0;
      while (!busy1 && guard < 10) begin tick(); guard++; end
      chk("load_after_en2", guard, 1);
      t = 1;
      run1_to(190);
      chk("pre_reset_row4_lit", {oe_n1, row_sel1, sclk1}, {1'b0, 8'h10, 1'b1});
      rst_n = 1'b0;
      #1;
      chk("async_reset_outs", outs1, RST_OUTS);
      en1 = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("idle_after_reset", outs1, RST_OUTS);
      en1 = 1'b1;
      tick();
      chk("restart_load", busy1, 1'b1);
      en1 = 1'b0;

      // DIV=3 protocol checks over one full frame.
      frame3 = F_3; en3 = 1'b1;
      guard = 0;
      while (!busy3 && guard < 10) begin tick(); guard++; end
      chk("load_after_en_div3", guard, 1);
      en3 = 1'b0;
      p_sclk = int'(sclk3); p_sdata = int'(sdata3); run = 0;
      last_change = -100; last_rise = -100; nr = 0; nlat = 0; lt0 = 0; fd3 = 0;
      bad_len = 0; bad_setup = 0; bad_hold = 0; bad_rises = 0;
      word3 = '0; w0 = '0; w7 = '0;
      for (int c = 2; c <= 793; c++) begin
         tick();
         if (int'(sclk3) != p_sclk) begin
            if (p_sclk == 1) begin
               if (run != 3) bad_len++;
            end else if (nr > 0 && run != 3) begin
               bad_len++;
            end
            run = 1;
            if (sclk3) begin
               nr++;
               word3 = {word3[14:0], sdata3};
               last_rise = c;
               if (c - last_change < 3) bad_setup++;
            end
         end else begin
            run++;
         end
         if (int'(sdata3) != p_sdata) begin
            if (c - last_rise < 3) bad_hold++;
            last_change = c;
         end
         p_sclk = int'(sclk3);
         p_sdata = int'(sdata3);
         if (slatch3) begin
            if (nr != 16) bad_rises++;
            if (nlat == 0) begin w0 = word3; lt0 = c; end
            if (nlat == 7) w7 = word3;
            nlat++;
            nr = 0;
            word3 = '0;
         end
         if (frame_done3) fd3 = c;
      end
      chk("div3_level_len", bad_len, 0);
      chk("div3_setup", bad_setup, 0);
      chk("div3_hold", bad_hold, 0);
      chk("div3_rises_per_latch", bad_rises, 0);
      chk("div3_latch_count", nlat, 8);
      chk("div3_latch0_time", lt0, 98);
      chk("div3_row0_bits", w0, 16'hA5C3);
      chk("div3_row7_bits", w7, 16'h0F0F);
      chk("div3_frame_done", fd3, 793);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/matrix_scanner.md
# matrix_scanner

Multiplexed LED-matrix driver that consumes the 128-bit glyph bitmap produced by the time-to-bitmap stage (8 rows × 16 columns) and scans it onto a row-multiplexed matrix. Each row's 16 column bits are shifted serially into an external latching shift-register chain, latched, then displayed for a programmable dwell time. The bitmap is snapshotted once per frame so that a time update mid-scan never tears the display.

## Interface
- `DIV`, 4: system clock cycles per `sclk` half-period; must be ≥ 1.
- `DWELL`, 1000: cycles a latched row is held after the latch pulse; must be ≥ 1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  scan enable; sampled in IDLE and at end of frame.
- `frame`  in  128  bitmap; row r = `frame[127-16r -: 16]`, column c = `frame[127-16r-c]`; 1 = LED on.
- `sdata`  out  1  serial column data to the shift chain.
- `sclk`  out  1  shift clock; the chain samples on the rising edge.
- `slatch`  out  1  storage-latch pulse for the chain.
- `oe_n`  out  1  chain output enable, active low.
- `row_sel`  out  8  one-hot row drive, active high; bit r = row r.
- `frame_done`  out  1  one-cycle pulse at end of row 7.
- `busy`  out  1  high in every state except IDLE.

## Operation
- All outputs are registered. Reset values: `sdata`=0, `sclk`=0, `slatch`=0, `oe_n`=1, `row_sel`=0, `frame_done`=0, `busy`=0; state IDLE, row=0.
- **IDLE**: `oe_n`=1, `row_sel`=0. If `en`=1, go to LOAD.
- **LOAD** (1 cycle): copy `frame` into the internal snapshot; row←0; go to SHIFT.
- **SHIFT**: shift 16 bits of the snapshot row, column 0 first, column 15 last. Per bit, `sdata` is set and `sclk`=0 for DIV cycles, then `sclk`=1 for DIV cycles. After bit 15 high phase, `sclk`←0 and go to LATCH. `oe_n` and `row_sel` keep their previous values, so the previous row stays lit while the next one is shifted.
- **LATCH** (1 cycle): `slatch`=1, `oe_n`=1, `row_sel`←one-hot(row). Go to DISPLAY.
- **DISPLAY** (DWELL cycles): `oe_n`=0. At expiry:
  - If row<7: row←row+1 and go to SHIFT.
  - If row=7: pulse `frame_done`, then go to LOAD if `en`=1, or to IDLE otherwise.
- Deasserting `en` mid-frame has no effect until row 7 completes.
- `frame` changes outside LOAD are ignored.
- Counters: the bit counter is 4 bits wide and wraps 15→0 only at the SHIFT exit. The divider and dwell counters are sized by $clog2 of their parameter and are reset on every state entry.
- Reset mid-operation forces reset values immediately, with `oe_n`=1 asynchronously, so no LED stays driven.

## Timing
- Row period = 32·DIV + 1 + DWELL cycles.
- Frame period = 1 + 8·(32·DIV + 1 + DWELL) cycles, LOAD to LOAD.
- `en` rise in IDLE: LOAD at the next cycle, then the first `sclk` rise DIV cycles after SHIFT entry.
- `sdata` is stable for the full DIV cycles before and after each `sclk` rise.
- `slatch` and the `row_sel` change happen in the same cycle, with `oe_n`=1 (ghost blanking).
- `frame_done` is coincident with the last DISPLAY cycle of row 7.

## Structure
- Shared package `matrix_pkg`:
  - constants `ROWS`=8, `COLS`=16, `FRAME_W`=128;
  - state enum {IDLE, LOAD, SHIFT, LATCH, DISPLAY};
  - function `row_bits(frame, r)` that returns the 16-bit row slice.
- One sub-module, `row_shifter`: a 16-bit PISO with the DIV tick generator. It has a start/done handshake and drives `sdata` and `sclk`.
- The top level holds the FSM, snapshot register, row counter and dwell counter.

## Test plan
- Reset with `en`=0, then release → all outputs hold their reset values for 1000 cycles; `busy`=0.
- DIV=1, DWELL=4, `frame` row 1 = 16'hE000, all other rows 0, `en`=1 → row 1 shifts 1,1,1 then thirteen 0s. `slatch` is high at cycle 1+37+33. `frame_done` fires at cycle 297 after LOAD.
- Change `frame` during row 3 of a frame → the remaining rows show the old snapshot. The new data appears only after the next LOAD.
- Drop `en` during row 2 → rows 3–7 complete, then `frame_done` fires. Next cycle: IDLE, `oe_n`=1, `row_sel`=0.
- Assert `rst_n`=0 during SHIFT of row 5 → `oe_n`=1 and `row_sel`=0 without waiting for a clock edge. After release the FSM restarts from IDLE.
- DIV=3 → each `sclk` level lasts exactly 3 cycles, and `sdata` does not change within 3 cycles of a rising edge. A protocol checker confirms 16 rising edges per `slatch`.
